keypad_matrix_scanner: RTL
==========================

Name: keypad_matrix_scanner

Overview:
- Scans a 4x4 matrix keypad and produces the 16-bit `key_data` word read by the AHB-Lite keyboard peripheral.
- Debounces each key over whole scan frames.
- Latches press events as sticky bits; the peripheral's one-cycle `key_clear` pulse clears them.
- Sits between the keypad pins (rows driven, columns sampled) and the AHB keyboard slave, in the HCLK domain.

Parameters:
- SCAN_CYCLES, 50000: HCLK cycles each row is driven (1 ms at 50 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive full frames a key must disagree with its debounced state before that state flips; must be >= 1.

Ports:
- HCLK  input  1  system clock
- HRESETn  input  1  asynchronous active-low reset
- row_n  output  4  keypad row drive, active-low, one-hot-low
- col_n  input  4  keypad column sense, active-low (external pull-ups), asynchronous
- key_clear  input  1  one-cycle pulse; clears all latched press bits
- key_data  output  16  sticky press flags; bit index = row*4 + col
- key_state  output  16  live debounced pressed state, same indexing
- key_irq  output  1  OR-reduction of key_data (registered)
- frame_tick  output  1  one-cycle pulse when a full 4-row frame completes

Behaviour:
- Clock and reset:
  - One clock, HCLK. Reset is asynchronous and active-low on HRESETn.
  - All registers reset asynchronously.
  - Reset values: row_n=4'b1110, key_data=0, key_state=0, key_irq=0, frame_tick=0, row index=0, cycle counter=0, column synchronizer=4'hF, all debounce counters=0.
- Column input:
  - col_n passes through a 2-flop synchronizer, reset to 4'hF.
  - `col_sync` is the inverted second stage (1 = pressed).
- Scan FSM:
  - Two counters: `cyc` runs 0..SCAN_CYCLES-1; `row` runs 0..3.
  - row_n = ~(4'b0001 << row), registered.
  - Each HCLK, `cyc` increments.
  - When cyc==SCAN_CYCLES-1: sample col_sync into raw[row*4 +: 4], set cyc=0, set row=row+1 (mod 4).
  - Sampling at the end of the row window absorbs the synchronizer latency and settling time.
- Frame completion:
  - A sample taken with row==3 completes the frame.
  - The debounce update uses the full 16-bit raw frame, including the row-3 bits captured in that same cycle.
  - frame_tick is asserted the following cycle, for exactly 1 cycle.
  - Frame period = 4*SCAN_CYCLES cycles.
- Debounce, per key k, evaluated only at frame completion:
  - If raw[k]==key_state[k]: cnt[k]=0.
  - Else if cnt[k]==DEBOUNCE_SCANS-1: key_state[k] toggles, cnt[k]=0.
  - Else: cnt[k]++.
  - A change therefore appears after exactly DEBOUNCE_SCANS consecutive disagreeing frames.
  - A single agreeing frame resets the count (glitch rejection).
- Press event:
  - key_state[k] going 0->1 raises press[k] for 1 cycle.
  - Release (1->0) generates no event.
- key_data update, each cycle: key_data <= (key_clear ? 16'h0 : key_data) | press.
  - A press event coinciding with key_clear leaves that bit set; all other bits clear.
  - key_clear with no pending bits has no effect.
  - key_clear never affects key_state, the debounce state or the scan.
  - Releasing a key does not clear its key_data bit.
- key_irq = |key_data, registered; lags key_data by 1 cycle.
- Multiple simultaneous keys are handled independently. Ghosting is not suppressed.
- Reset mid-scan: everything returns to reset values immediately. Scanning restarts at row 0 with a full SCAN_CYCLES window after HRESETn deasserts. Any partial frame is discarded.
- No combinational path from col_n to any output.

Test Plan:
- Bench parameters: SCAN_CYCLES=8, DEBOUNCE_SCANS=2.
- 1. Scan sequence: release reset, no keys pressed -> row_n cycles 1110, 1101, 1011, 0111, each held 8 cycles. frame_tick pulses every 32 cycles. key_data, key_state and key_irq stay 0.
- 2. Debounce timing: hold key row1/col2 (col_n[2] low while row_n[1] low) from the start of a frame -> key_state = 16'h0040 after the 2nd frame completes, not the 1st. key_data = 16'h0040; key_irq = 1 one cycle later.
- 3. Sticky and clear: after scenario 2, release the key -> key_state returns to 0 after 2 frames while key_data remains 16'h0040. Pulse key_clear -> key_data = 0 next cycle; key_irq = 0 the cycle after.
- 4. Glitch rejection: press key row0/col0 for exactly one frame, then release -> key_state and key_data remain 0. Then hold row3/col3 for 2 frames -> key_data = 16'h8000.
- 5. Clear collision: with key_data = 16'h0001 pending, assert key_clear in the same cycle that row2/col1's press event occurs -> key_data = 16'h0200. Bit 0 is cleared, bit 9 is set.
- 6. Reset mid-operation: assert HRESETn low while row 2 is driven and key_data = 16'h0010 -> all outputs return to reset values immediately, row_n = 1110. After release, the first frame_tick arrives 32+1 cycles later.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
//
// Purpose:
//   Scans a 4x4 active-low matrix keypad by driving one row low at a time and
//   sampling the columns at the end of each row window. Each key is debounced
//   over whole scan frames. A key going from released to pressed sets a sticky
//   bit in key_data, which the AHB keyboard peripheral clears with a one-cycle
//   key_clear pulse. Everything runs in the HCLK domain.
//
// Ports:
//   HCLK        system clock
//   HRESETn     asynchronous active-low reset
//   row_n       row drive, active-low, one row low at a time (registered)
//   col_n       column sense, active-low with external pull-ups, asynchronous
//   key_clear   one-cycle pulse that clears all latched press bits
//   key_data    sticky press flags, bit index = row*4 + col
//   key_state   live debounced pressed state, same indexing
//   key_irq     registered OR of key_data
//   frame_tick  one-cycle pulse after each completed 4-row frame
//
// Parameters:
//   SCAN_CYCLES     HCLK cycles each row is driven (>= 4)
//   DEBOUNCE_SCANS  consecutive disagreeing frames needed to flip a key (>= 1)

module keypad_matrix_scanner #(
  parameter int SCAN_CYCLES    = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  input  logic        key_clear,
  output logic [15:0] key_data,
  output logic [15:0] key_state,
  output logic        key_irq,
  output logic        frame_tick
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_SCANS - 1);

  logic [3:0]    col_meta;
  logic [3:0]    col_ff;
  logic [3:0]    col_sync;
  logic [CW-1:0] cyc;
  logic [1:0]    row;
  logic [11:0]   raw_lo;
  logic [15:0]   frame_raw;
  logic          row_end;
  logic          frame_done;
  logic [DW-1:0] cnt      [16];
  logic [DW-1:0] cnt_next [16];
  logic [15:0]   state_next;
  logic [15:0]   press;

  // Two-flop synchronizer; idles at all-ones so nothing looks pressed out of reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col_meta <= 4'hF;
      col_ff   <= 4'hF;
    end else begin
      col_meta <= col_n;
      col_ff   <= col_meta;
    end
  end

  assign col_sync   = ~col_ff;
  assign row_end    = (cyc == CYC_LAST);
  assign frame_done = row_end && (row == 2'd3);

  // Row 3 is never stored: its columns are used directly in the same cycle
  // the frame completes, so the debounce sees the complete 16-bit frame.
  assign frame_raw = {col_sync, raw_lo};

  // Scan timing. Columns are sampled on the last cycle of each row window so
  // that the synchronizer latency and the keypad settling time are absorbed.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cyc    <= '0;
      row    <= 2'd0;
      row_n  <= 4'b1110;
      raw_lo <= '0;
    end else if (row_end) begin
      cyc   <= '0;
      row   <= row + 2'd1;
      row_n <= ~(4'b0001 << (row + 2'd1));
      case (row)
        2'd0:    raw_lo[3:0]  <= col_sync;
        2'd1:    raw_lo[7:4]  <= col_sync;
        2'd2:    raw_lo[11:8] <= col_sync;
        default: raw_lo       <= raw_lo;
      endcase
    end else begin
      cyc <= cyc + CW'(1);
    end
  end

  // Per-key debounce, evaluated once per completed frame. A key flips only
  // after DEBOUNCE_SCANS consecutive disagreeing frames; any agreeing frame
  // restarts the count. A 0->1 flip produces a one-cycle press event that is
  // aligned with the key_state update.
  always_comb begin
    state_next = key_state;
    press      = '0;
    for (int k = 0; k < 16; k++) begin
      cnt_next[k] = cnt[k];
    end
    if (frame_done) begin
      for (int k = 0; k < 16; k++) begin
        if (frame_raw[k] == key_state[k]) begin
          cnt_next[k] = '0;
        end else if (cnt[k] == CNT_LAST) begin
          state_next[k] = ~key_state[k];
          press[k]      = ~key_state[k];
          cnt_next[k]   = '0;
        end else begin
          cnt_next[k] = cnt[k] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      key_state <= '0;
      for (int k = 0; k < 16; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      key_state <= state_next;
      for (int k = 0; k < 16; k++) begin
        cnt[k] <= cnt_next[k];
      end
    end
  end

  // Sticky press flags. A press arriving in the same cycle as key_clear
  // survives the clear so no event is ever lost. The irq is a registered OR
  // and therefore trails key_data by one cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      key_data   <= '0;
      key_irq    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      key_data   <= (key_clear ? 16'h0000 : key_data) | press;
      key_irq    <= |key_data;
      frame_tick <= frame_done;
    end
  end

endmodule
